// File: rtl/ps2_console_keys.sv
// PS/2 set-2 receiver and console-key decoder for the 2600 core.
// Define PS2_JOY_EN to decode arrows/space/ctrl/alt into joy0_out.
module ps2_console_keys #(
  parameter logic [15:0] TIMEOUT = 16'd2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [5:0] joy0_in,
  output logic [5:0] joy0_out,
  output logic       con_reset,
  output logic       con_select,
  output logic       con_bw,
  output logic       diff_p0,
  output logic       diff_p1,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  typedef enum logic {IDLE, SHIFT} rx_state_t;

  rx_state_t   state;
  logic        clk_s1, clk_s2, clk_prev;
  logic        data_s1, data_s2;
  logic        fall;
  logic [3:0]  bit_cnt;
  logic [8:0]  shreg;
  logic [15:0] to_cnt;

  logic ext, brk, pressed;
  logic f3_held, f5_held, f6_held;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      to_cnt     <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      scan_code  <= '0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall)
        to_cnt <= '0;
      else if (to_cnt != '1)
        to_cnt <= to_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (fall) begin
            if (!data_s2) begin
              state   <= SHIFT;
              bit_cnt <= 4'd1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (fall) begin
            if (bit_cnt == 4'd10) begin
              state   <= IDLE;
              bit_cnt <= '0;
              // shreg holds 8 data bits plus parity; a good frame has odd weight
              if (data_s2 && (^shreg)) begin
                scan_code  <= shreg[7:0];
                scan_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              shreg   <= {data_s2, shreg[8:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (to_cnt >= TIMEOUT) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pressed = ~brk;

`ifdef PS2_JOY_EN
  logic right_h, left_h, down_h, up_h, space_h, rctrl_h, alt_h;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      con_reset  <= 1'b0;
      con_select <= 1'b0;
      con_bw     <= 1'b0;
      diff_p0    <= 1'b0;
      diff_p1    <= 1'b0;
      f3_held    <= 1'b0;
      f5_held    <= 1'b0;
      f6_held    <= 1'b0;
`ifdef PS2_JOY_EN
      right_h    <= 1'b0;
      left_h     <= 1'b0;
      down_h     <= 1'b0;
      up_h       <= 1'b0;
      space_h    <= 1'b0;
      rctrl_h    <= 1'b0;
      alt_h      <= 1'b0;
`endif
    end else if (scan_valid) begin
      if (scan_code == 8'hE0) begin
        ext <= 1'b1;
      end else if (scan_code == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (!ext) begin
          // toggles flip only on the first make; typematic repeats see held=1
          case (scan_code)
            8'h05: con_reset  <= pressed;
            8'h06: con_select <= pressed;
            8'h04: begin
              if (pressed && !f3_held) con_bw <= ~con_bw;
              f3_held <= pressed;
            end
            8'h03: begin
              if (pressed && !f5_held) diff_p0 <= ~diff_p0;
              f5_held <= pressed;
            end
            8'h0B: begin
              if (pressed && !f6_held) diff_p1 <= ~diff_p1;
              f6_held <= pressed;
            end
`ifdef PS2_JOY_EN
            8'h29: space_h <= pressed;
            8'h11: alt_h   <= pressed;
`endif
            default: ;
          endcase
        end
`ifdef PS2_JOY_EN
        else begin
          case (scan_code)
            8'h74: right_h <= pressed;
            8'h6B: left_h  <= pressed;
            8'h72: down_h  <= pressed;
            8'h75: up_h    <= pressed;
            8'h14: rctrl_h <= pressed;
            default: ;
          endcase
        end
`endif
      end
    end
  end

`ifdef PS2_JOY_EN
  logic [5:0] kbd_joy;
  assign kbd_joy  = {alt_h, space_h | rctrl_h, up_h, down_h, left_h, right_h};
  assign joy0_out = joy0_in | kbd_joy;
`else
  assign joy0_out = joy0_in;
`endif

endmodule

// File: tb/tb_ps2_console_keys.sv
// Scoreboard bench for ps2_console_keys: key-level reference model, randomized frames.
module tb_ps2_console_keys;

  localparam int          H   = 6;
  localparam logic [15:0] TMO = 16'd2000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [5:0] joy0_in = '0;
  logic [5:0] joy0_out;
  logic       con_reset, con_select, con_bw, diff_p0, diff_p1;
  logic       scan_valid, frame_err;
  logic [7:0] scan_code;

  ps2_console_keys #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .joy0_in(joy0_in), .joy0_out(joy0_out), .con_reset(con_reset),
    .con_select(con_select), .con_bw(con_bw), .diff_p0(diff_p0),
    .diff_p1(diff_p1), .scan_valid(scan_valid), .scan_code(scan_code),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    bit         timed;
    logic [7:0] code;
    logic [5:0] joy;
    bit         rst, sel, bw, p0, p1;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  fall_cyc = 0;

  // reference model: held state per {ext, code} key plus the three latches
  bit         m_held[bit [8:0]];
  bit         m_ext, m_brk, m_bw, m_p0, m_p1;
  logic [7:0] m_code;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit held(input bit [8:0] k);
    return m_held.exists(k) ? m_held[k] : 1'b0;
  endfunction

  function automatic logic [5:0] m_joy();
`ifdef PS2_JOY_EN
    return {held(9'h011), held(9'h029) | held(9'h114), held(9'h175),
            held(9'h172), held(9'h16B), held(9'h174)};
`else
    return 6'b0;
`endif
  endfunction

  function automatic ev_t snapshot(input bit e, input bit t);
    ev_t s;
    s.is_err = e;
    s.timed  = t;
    s.code   = m_code;
    s.joy    = m_joy();
    s.rst    = held(9'h005);
    s.sel    = held(9'h006);
    s.bw     = m_bw;
    s.p0     = m_p0;
    s.p1     = m_p1;
    return s;
  endfunction

  task automatic model_reset();
    m_held.delete();
    m_ext = 0; m_brk = 0; m_bw = 0; m_p0 = 0; m_p1 = 0;
    m_code = 8'h00;
  endtask

  task automatic model_code(input logic [7:0] c);
    bit [8:0] k;
    bit       pr;
    m_code = c;
    if (c == 8'hE0) m_ext = 1;
    else if (c == 8'hF0) m_brk = 1;
    else begin
      k  = {m_ext, c};
      pr = !m_brk;
      if (pr && !held(k)) begin
        if (k == 9'h004) m_bw = !m_bw;
        if (k == 9'h003) m_p0 = !m_p0;
        if (k == 9'h00B) m_p1 = !m_p1;
      end
      m_held[k] = pr;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input bit b);
    ps2_data = b;
    tick(H);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    tick(H);
    ps2_clk  = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      tick(1);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending events", q.size());
      q.delete();
    end
    tick(4);
  endtask

  task automatic send_frame(input logic [7:0] c, input bit bad_par);
    bit par;
    wait_idle();
    joy0_in = 6'($urandom);
    #1;
    check("joy_comb", joy0_out, joy0_in | m_joy());
    if (bad_par) q.push_back(snapshot(1, 1));
    else begin
      model_code(c);
      q.push_back(snapshot(0, 1));
    end
    par = bad_par ? (^c) : ~(^c);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(c[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    tick(H);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_joy"}, joy0_out, joy0_in);
    check({tag, "_rst"}, con_reset, 0);
    check({tag, "_sel"}, con_select, 0);
    check({tag, "_bw"}, con_bw, 0);
    check({tag, "_p0"}, diff_p0, 0);
    check({tag, "_p1"}, diff_p1, 0);
    check({tag, "_valid"}, scan_valid, 0);
    check({tag, "_code"}, scan_code, 0);
    check({tag, "_err"}, frame_err, 0);
  endtask

  // monitor: pops one expected event per DUT pulse, then checks key outputs a cycle later
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (scan_valid || frame_err) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse actual valid=%0b err=%0b code=%0h expected none",
                   scan_valid, frame_err, scan_code);
        end else begin
          e = q.pop_front();
          check("frame_err", frame_err, e.is_err);
          check("scan_valid", scan_valid, !e.is_err);
          check("scan_code", scan_code, e.code);
          if (e.timed) check("latency", cyc - fall_cyc, 3);
          @(negedge clk);
          check("scan_valid_pulse", scan_valid, 0);
          check("frame_err_pulse", frame_err, 0);
          check("joy0_out", joy0_out, joy0_in | e.joy);
          check("con_reset", con_reset, e.rst);
          check("con_select", con_select, e.sel);
          check("con_bw", con_bw, e.bw);
          check("diff_p0", diff_p0, e.p0);
          check("diff_p1", diff_p1, e.p1);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pool [15];
    pool = '{8'h05, 8'h06, 8'h04, 8'h03, 8'h0B, 8'h29, 8'h11, 8'h74,
             8'h6B, 8'h72, 8'h75, 8'h14, 8'hE0, 8'hF0, 8'h1C};
    model_reset();
    tick(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick(4);

    send_frame(8'h05, 0);
    wait_idle();
    check("f1_held", con_reset, 1);
    send_frame(8'hF0, 0);
    send_frame(8'h05, 0);
    wait_idle();
    check("f1_released", con_reset, 0);

    repeat (3) send_frame(8'h04, 0);
    wait_idle();
    check("bw_typematic", con_bw, 1);
    send_frame(8'hF0, 0);
    send_frame(8'h04, 0);
    send_frame(8'h04, 0);
    wait_idle();
    check("bw_second_press", con_bw, 0);

    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    wait_idle();
    joy0_in = 6'b000001;
    #1;
`ifdef PS2_JOY_EN
    check("joy_up", joy0_out, 6'b001001);
`else
    check("joy_up", joy0_out, 6'b000001);
`endif
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    wait_idle();
    joy0_in = 6'b000001;
    #1;
    check("joy_up_break", joy0_out, 6'b000001);

    send_frame(8'h1C, 1);

    wait_idle();
    q.push_back(snapshot(1, 0));
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom));
    tick(int'(TMO) + 10);
    send_frame(8'h0B, 0);
    wait_idle();
    check("p1_after_timeout", diff_p1, 1);

    send_frame(8'h03, 0);
    wait_idle();
    check("p0_latched", diff_p0, 1);
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    model_reset();
    check_reset_outputs("midreset");
    tick(H);
    send_frame(8'h06, 0);
    wait_idle();
    check("sel_after_reset", con_select, 1);

    for (int n = 0; n < 120; n++)
      send_frame(pool[$urandom_range(0, 14)], ($urandom_range(0, 11) == 0));
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
